// File: rtl/pkt_comm_pkg.sv
// Shared constants, FSM encoding and checksum helpers for the AXIS8 packet framer.
package pkt_comm_pkg;
  localparam int HDR_LEN  = 10;
  localparam int CSUM_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HCSUM,
    ST_PAYLOAD,
    ST_PFIN,
    ST_PCSUM
  } state_t;

  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

  function automatic logic [31:0] csum_final(input logic [31:0] acc);
    return ~acc;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Header layout: ver, type, 0, 0, len[23:0] LE, 0, id[15:0] LE
  function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [7:0]  ver,
                                          input logic [7:0]  typ,
                                          input logic [15:0] id,
                                          input logic [23:0] len);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ver;
      4'd1:    b = typ;
      4'd4:    b = len[7:0];
      4'd5:    b = len[15:8];
      4'd6:    b = len[23:16];
      4'd8:    b = id[7:0];
      4'd9:    b = id[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction
endpackage

// File: rtl/axis8_pkt_framer_if.sv
// Descriptor, payload-in, framed-out and status bundle of the AXIS8 packet framer.
interface axis8_pkt_framer_if #(
  parameter int PKT_LEN_MSB = 23
);
  logic                 start;
  logic [7:0]           pkt_type;
  logic [15:0]          pkt_id;
  logic [PKT_LEN_MSB:0] pkt_len;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic                 busy;
  logic                 err_short;
  logic                 err_long;
  logic                 err_clr;

  // master: the framer itself; slave: host / downstream environment
  modport master (
    input  start, pkt_type, pkt_id, pkt_len,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, err_clr,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output busy, err_short, err_long
  );
  modport slave (
    output start, pkt_type, pkt_id, pkt_len,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, err_clr,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  busy, err_short, err_long
  );
endinterface

// File: rtl/pkt_csum32.sv
// Byte-serial little-endian 32-bit word summer. sum already includes the
// zero-padded partial word, so it is usable on the same edge as the last byte.
module pkt_csum32
  import pkt_comm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic [31:0] sum
);
  logic [31:0] r_acc;
  logic [31:0] r_word;
  logic [1:0]  r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_word <= '0;
      r_idx  <= '0;
    end else if (clr) begin
      r_acc  <= '0;
      r_word <= '0;
      r_idx  <= '0;
    end else if (flush) begin
      r_acc  <= csum_add(r_acc, r_word);
      r_word <= '0;
      r_idx  <= '0;
    end else if (byte_en) begin
      if (r_idx == 2'd3) begin
        r_acc  <= csum_add(r_acc, {byte_in, r_word[23:0]});
        r_word <= '0;
      end else begin
        r_word[{r_idx, 3'b000} +: 8] <= byte_in;
      end
      r_idx <= r_idx + 2'd1;
    end
  end

  assign sum = csum_add(r_acc, r_word);
endmodule

// File: rtl/axis8_pkt_framer.sv
// Wraps a payload byte stream into a pkt_comm packet: header, header checksum,
// pass-through payload, payload checksum (TLAST on its last byte).
module axis8_pkt_framer
  import pkt_comm_pkg::*;
#(
  parameter logic [7:0] VERSION     = 8'd2,
  parameter int         PKT_LEN_MSB = 23
) (
  input logic              CORE_CLK,
  input logic              CORE_RST,
  axis8_pkt_framer_if.master bus
);
  state_t               r_state, w_nstate;
  logic [3:0]           r_cnt, w_cnt_n;
  logic [PKT_LEN_MSB:0] r_pcnt, w_pcnt_n, w_pcnt_inc, r_len;
  logic [7:0]           r_type;
  logic [15:0]          r_id;
  logic [7:0]           r_tdata, w_tdata_n;
  logic                 r_tvalid, w_tvalid_n, r_tlast, w_tlast_n;
  logic [31:0]          r_csum, w_csum_n, w_sum, w_fin;
  logic                 r_err_short, r_err_long, w_set_short, w_set_long;
  logic                 w_acc_clr, w_acc_en, w_acc_flush;
  logic [7:0]           w_acc_byte, w_hbyte;
  logic [1:0]           w_cidx;
  logic                 w_accept, w_oxfer, w_pxfer, w_in_pay;

  pkt_csum32 u_csum (
    .clk     (CORE_CLK),
    .rst     (CORE_RST),
    .clr     (w_acc_clr),
    .byte_en (w_acc_en),
    .byte_in (w_acc_byte),
    .flush   (w_acc_flush),
    .sum     (w_sum)
  );

  assign w_in_pay   = (r_state == ST_PAYLOAD);
  assign w_accept   = (r_state == ST_IDLE) & bus.start;
  assign w_oxfer    = r_tvalid & bus.m_axis_tready;
  assign w_pxfer    = w_in_pay & bus.s_axis_tvalid & bus.m_axis_tready;
  assign w_pcnt_inc = r_pcnt + {{PKT_LEN_MSB{1'b0}}, 1'b1};
  assign w_fin      = csum_final(w_sum);
  assign w_cidx     = r_cnt[1:0] + 2'd1;
  // Header bytes are summed as they are loaded, one byte ahead of the wire
  assign w_hbyte    = hdr_byte(r_cnt + 4'd1, VERSION, r_type, r_id, 24'(r_len));

  always_ff @(posedge CORE_CLK or posedge CORE_RST) begin
    if (CORE_RST) r_state <= ST_IDLE;
    else          r_state <= w_nstate;
  end

  always_comb begin
    w_nstate    = r_state;
    w_cnt_n     = r_cnt;
    w_pcnt_n    = r_pcnt;
    w_tdata_n   = r_tdata;
    w_tvalid_n  = r_tvalid;
    w_tlast_n   = r_tlast;
    w_csum_n    = r_csum;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    w_acc_flush = 1'b0;
    w_acc_byte  = 8'h00;
    w_set_short = 1'b0;
    w_set_long  = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.start) begin
        w_nstate   = ST_HDR;
        w_cnt_n    = '0;
        w_tdata_n  = VERSION;
        w_tvalid_n = 1'b1;
        w_acc_en   = 1'b1;
        w_acc_byte = VERSION;
      end
      ST_HDR: if (w_oxfer) begin
        if (r_cnt == 4'(HDR_LEN - 1)) begin
          w_nstate  = ST_HCSUM;
          w_cnt_n   = '0;
          w_csum_n  = w_fin;
          w_tdata_n = byte_of(w_fin, 2'd0);
          w_acc_clr = 1'b1;
        end else begin
          w_cnt_n    = r_cnt + 4'd1;
          w_tdata_n  = w_hbyte;
          w_acc_en   = 1'b1;
          w_acc_byte = w_hbyte;
        end
      end
      ST_HCSUM: if (w_oxfer) begin
        if (r_cnt == 4'(CSUM_LEN - 1)) begin
          w_tvalid_n = 1'b0;
          w_pcnt_n   = '0;
          w_nstate   = (r_len == '0) ? ST_PFIN : ST_PAYLOAD;
        end else begin
          w_cnt_n   = r_cnt + 4'd1;
          w_tdata_n = byte_of(r_csum, w_cidx);
        end
      end
      ST_PAYLOAD: if (w_pxfer) begin
        w_acc_en   = 1'b1;
        w_acc_byte = bus.s_axis_tdata;
        w_pcnt_n   = w_pcnt_inc;
        if (w_pcnt_inc == r_len) begin
          w_nstate   = ST_PFIN;
          w_set_long = ~bus.s_axis_tlast;
        end else if (bus.s_axis_tlast) begin
          w_nstate    = ST_PFIN;
          w_set_short = 1'b1;
        end
      end
      ST_PFIN: begin
        w_acc_flush = 1'b1;
        w_nstate    = ST_PCSUM;
        w_cnt_n     = '0;
        w_csum_n    = w_fin;
        w_tdata_n   = byte_of(w_fin, 2'd0);
        w_tvalid_n  = 1'b1;
        w_tlast_n   = 1'b0;
      end
      ST_PCSUM: if (w_oxfer) begin
        if (r_cnt == 4'(CSUM_LEN - 1)) begin
          w_nstate   = ST_IDLE;
          w_tvalid_n = 1'b0;
          w_tlast_n  = 1'b0;
          w_acc_clr  = 1'b1;
        end else begin
          w_cnt_n   = r_cnt + 4'd1;
          w_tdata_n = byte_of(r_csum, w_cidx);
          w_tlast_n = (w_cidx == 2'd3);
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge CORE_CLK or posedge CORE_RST) begin
    if (CORE_RST) begin
      r_cnt       <= '0;
      r_pcnt      <= '0;
      r_len       <= '0;
      r_type      <= '0;
      r_id        <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_csum      <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_pcnt   <= w_pcnt_n;
      r_tdata  <= w_tdata_n;
      r_tvalid <= w_tvalid_n;
      r_tlast  <= w_tlast_n;
      r_csum   <= w_csum_n;
      if (w_accept) begin
        r_len  <= bus.pkt_len;
        r_type <= bus.pkt_type;
        r_id   <= bus.pkt_id;
      end
      // a set event wins over a simultaneous clear
      r_err_short <= (r_err_short & ~bus.err_clr) | w_set_short;
      r_err_long  <= (r_err_long  & ~bus.err_clr) | w_set_long;
    end
  end

  assign bus.m_axis_tdata  = w_in_pay ? bus.s_axis_tdata  : r_tdata;
  assign bus.m_axis_tvalid = w_in_pay ? bus.s_axis_tvalid : r_tvalid;
  assign bus.m_axis_tlast  = w_in_pay ? 1'b0 : r_tlast;
  assign bus.s_axis_tready = w_in_pay & bus.m_axis_tready;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.err_short     = r_err_short;
  assign bus.err_long      = r_err_long;
endmodule

// File: tb/tb_axis8_pkt_framer.sv
// Randomized bench for axis8_pkt_framer against a queue-based packet model.
module tb_axis8_pkt_framer;
  localparam logic [7:0] VER = 8'd2;

  typedef struct packed { logic [7:0] d; logic l; } sb_t;
  typedef logic [7:0] bq_t[$];

  logic clk, rst;
  int   n_chk, n_pass, rdy_pct;
  sb_t  drv_q[$], mdl_q[$], out_q[$];
  logic prev_stall, last_busy;
  logic [7:0] prev_data;
  logic [7:0] gold [22];

  axis8_pkt_framer_if #(.PKT_LEN_MSB(23)) bus ();

  axis8_pkt_framer #(.VERSION(VER), .PKT_LEN_MSB(23)) dut (
    .CORE_CLK (clk),
    .CORE_RST (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_csum(input bq_t q);
    logic [31:0] s;
    s = 32'h0;
    foreach (q[i]) s = s + ({24'h0, q[i]} << (8 * (i % 4)));
    return ~s;
  endfunction

  task automatic feed(input logic [7:0] d, input logic l);
    sb_t x;
    x.d = d; x.l = l;
    drv_q.push_back(x);
    mdl_q.push_back(x);
  endtask

  // observe at negedge, drive at posedge+1
  task automatic cycle();
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_vld", {31'h0, bus.m_axis_tvalid}, 32'd1);
      chk("hold_dat", {24'h0, bus.m_axis_tdata}, {24'h0, prev_data});
    end
    prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_data  = bus.m_axis_tdata;
    last_busy  = bus.busy;
    if (bus.m_axis_tvalid && bus.m_axis_tready) out_q.push_back({bus.m_axis_tdata, bus.m_axis_tlast});
    if (bus.s_axis_tvalid && bus.s_axis_tready) void'(drv_q.pop_front());
    @(posedge clk); #1;
    bus.m_axis_tready = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
    if (drv_q.size() > 0) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = drv_q[0].d;
      bus.s_axis_tlast  = drv_q[0].l;
    end else begin
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = 8'h00;
      bus.s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [7:0] typ, input logic [15:0] id, input logic [23:0] len,
                          input int rdy, input bit junk);
    bq_t hq, pq;
    sb_t eq[$];
    sb_t b;
    logic [31:0] hs, ps;
    bit sh, lg, done;
    int plen, n;
    sh = 0; lg = 0; plen = int'(len);
    hq = {VER, typ, 8'h00, 8'h00, len[7:0], len[15:8], len[23:16], 8'h00, id[7:0], id[15:8]};
    while (pq.size() < plen && mdl_q.size() > 0) begin
      b = mdl_q.pop_front();
      pq.push_back(b.d);
      if (pq.size() == plen) begin lg = !b.l; break; end
      if (b.l) begin sh = 1; break; end
    end
    hs = ref_csum(hq);
    ps = ref_csum(pq);
    foreach (hq[i]) eq.push_back({hq[i], 1'b0});
    for (int k = 0; k < 4; k++) eq.push_back({hs[8*k +: 8], 1'b0});
    foreach (pq[i]) eq.push_back({pq[i], 1'b0});
    for (int k = 0; k < 4; k++) eq.push_back({ps[8*k +: 8], 1'b0});
    eq[eq.size()-1].l = 1'b1;

    out_q.delete();
    rdy_pct = rdy;
    bus.pkt_type = typ; bus.pkt_id = id; bus.pkt_len = len; bus.start = 1'b1;
    cycle();
    bus.start = junk;
    bus.pkt_type = 8'($urandom); bus.pkt_id = 16'($urandom); bus.pkt_len = 24'($urandom_range(9, 1));
    #3;
    chk("hdr0_vld", {31'h0, bus.m_axis_tvalid}, 32'd1);
    chk("hdr0_dat", {24'h0, bus.m_axis_tdata}, {24'h0, VER});
    chk("busy_rise", {31'h0, bus.busy}, 32'd1);
    done = 0; n = 0;
    while (!done && n < 2000) begin
      cycle(); n++;
      done = (out_q.size() > 0) && out_q[out_q.size()-1].l;
      bus.start = junk && !done;
    end
    chk("timeout", {31'h0, done}, 32'd1);
    chk("nbytes", out_q.size(), eq.size());
    for (int i = 0; i < eq.size() && i < out_q.size(); i++) begin
      chk($sformatf("byte%0d", i), {24'h0, out_q[i].d}, {24'h0, eq[i].d});
      chk($sformatf("last%0d", i), {31'h0, out_q[i].l}, {31'h0, eq[i].l});
    end
    chk("busy_last", {31'h0, last_busy}, 32'd1);
    #2;
    chk("busy_fall", {31'h0, bus.busy}, 32'd0);
    chk("idle_vld", {31'h0, bus.m_axis_tvalid}, 32'd0);
    chk("err_short", {31'h0, bus.err_short}, {31'h0, sh});
    chk("err_long", {31'h0, bus.err_long}, {31'h0, lg});
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    #2;
    chk("clr_short", {31'h0, bus.err_short}, 32'd0);
    chk("clr_long", {31'h0, bus.err_long}, 32'd0);
  endtask

  task automatic chk_gold();
    for (int i = 0; i < 22; i++)
      chk($sformatf("gold%0d", i), (i < out_q.size()) ? {24'h0, out_q[i].d} : 32'hdead, {24'h0, gold[i]});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_vld"}, {31'h0, bus.m_axis_tvalid}, 32'd0);
    chk({tag, "_last"}, {31'h0, bus.m_axis_tlast}, 32'd0);
    chk({tag, "_dat"}, {24'h0, bus.m_axis_tdata}, 32'd0);
    chk({tag, "_srdy"}, {31'h0, bus.s_axis_tready}, 32'd0);
    chk({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
    chk({tag, "_errs"}, {31'h0, bus.err_short}, 32'd0);
    chk({tag, "_errl"}, {31'h0, bus.err_long}, 32'd0);
  endtask

  initial begin
    int len, mode, k, n;
    n_chk = 0; n_pass = 0; rdy_pct = 100;
    prev_stall = 0; prev_data = 0; last_busy = 0;
    gold = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'hC5,
             8'hEC, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFE, 8'hFD, 8'hFC, 8'hFB};
    rst = 1'b1;
    bus.start = 0; bus.pkt_type = 0; bus.pkt_id = 0; bus.pkt_len = 0;
    bus.s_axis_tdata = 0; bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
    bus.m_axis_tready = 0; bus.err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("rst");
    rst = 1'b0;
    cycle();

    // reference packet, full rate then with backpressure
    feed(8'h01, 0); feed(8'h02, 0); feed(8'h03, 0); feed(8'h04, 1);
    send_pkt(8'h01, 16'h1234, 24'd4, 100, 0);
    chk_gold();
    feed(8'h01, 0); feed(8'h02, 0); feed(8'h03, 0); feed(8'h04, 1);
    send_pkt(8'h01, 16'h1234, 24'd4, 50, 1);
    chk_gold();

    send_pkt(8'h07, 16'hbeef, 24'd0, 70, 0);

    // short: TLAST on byte 3 of 6
    feed(8'h11, 0); feed(8'h22, 0); feed(8'h33, 1);
    send_pkt(8'h03, 16'h0042, 24'd6, 80, 0);

    // long: third byte must stay parked
    feed(8'hA1, 0); feed(8'hA2, 0); feed(8'hA3, 0);
    send_pkt(8'h04, 16'h5555, 24'd2, 100, 0);
    repeat (4) cycle();
    chk("park_rdy", {31'h0, bus.s_axis_tready}, 32'd0);
    chk("park_cnt", drv_q.size(), 32'd1);
    feed(8'hB1, 0); feed(8'hB2, 0); feed(8'hB3, 0); feed(8'hB4, 1);
    send_pkt(8'h05, 16'h0102, 24'd5, 60, 0);

    for (int p = 0; p < 8; p++) begin
      len  = $urandom_range(40);
      mode = $urandom_range(3);
      k    = len;
      if (mode == 2 && len >= 2) k = $urandom_range(len - 1, 1);
      for (int i = 0; i < k; i++) feed(8'($urandom), (i == k - 1) && (mode != 3));
      send_pkt(8'($urandom), 16'($urandom), 24'(len), $urandom_range(100, 30), p[0]);
    end

    // reset in the middle of the payload
    for (int i = 0; i < 20; i++) feed(8'(i * 7 + 1), i == 19);
    rdy_pct = 100; out_q.delete();
    bus.pkt_type = 8'h09; bus.pkt_id = 16'h0909; bus.pkt_len = 24'd20; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    n = 0;
    while (out_q.size() < 17 && n < 200) begin cycle(); n++; end
    chk("mid_reach", {31'h0, (out_q.size() >= 17)}, 32'd1);
    rst = 1'b1;
    #3;
    chk_quiet("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    drv_q.delete(); mdl_q.delete(); prev_stall = 0;
    bus.s_axis_tvalid = 0;
    cycle();
    feed(8'hC1, 0); feed(8'hC2, 0); feed(8'hC3, 1);
    send_pkt(8'h0A, 16'hCAFE, 24'd3, 75, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis8_pkt_framer.md
# axis8_pkt_framer

Upstream framing stage for the bcrypt AXIS8 input path. It takes a raw payload byte stream plus sideband packet descriptors (type, id, length) from the LiteX host side and emits a complete pkt_comm input packet on an 8-bit AXI4-Stream: header, header checksum, payload, payload checksum. TLAST is asserted on the final checksum byte. The output connects directly to the bcrypt wrapper's `s_axis_*` input.

## Interface
- `VERSION`, default 2: pkt_comm version byte placed in header byte 0.
- `PKT_LEN_MSB`, default 23: MSB of the payload length field, which is 24 bits.
- `CORE_CLK` in 1: single clock.
- `CORE_RST` in 1: asynchronous, active-high reset.
- `start` in 1: descriptor strobe. Accepted only when `busy`=0; ignored otherwise.
- `pkt_type` in 8: packet type. Sampled on an accepted `start`.
- `pkt_id` in 16: packet id. Sampled on an accepted `start`.
- `pkt_len` in PKT_LEN_MSB+1: payload byte count. Sampled on an accepted `start`. Zero is legal.
- `s_axis_tdata` in 8: payload byte in.
- `s_axis_tvalid` in 1: payload byte valid.
- `s_axis_tready` out 1: payload byte ready.
- `s_axis_tlast` in 1: payload end marker.
- `m_axis_tdata` out 8: framed byte out.
- `m_axis_tvalid` out 1: framed byte valid.
- `m_axis_tready` in 1: framed byte ready.
- `m_axis_tlast` out 1: framed packet end.
- `busy` out 1: high from an accepted `start` until the last checksum byte is accepted.
- `err_short` out 1: sticky. Input TLAST arrived before `pkt_len` bytes.
- `err_long` out 1: sticky. `pkt_len` bytes consumed without TLAST on the last one.
- `err_clr` in 1: clears both sticky error flags.

## Operation
- Header is 10 bytes:
  - byte 0 = VERSION
  - byte 1 = type
  - bytes 2–3 = 0
  - bytes 4–6 = length, little-endian
  - byte 7 = 0
  - bytes 8–9 = id, little-endian
- Checksum: 32-bit sum of little-endian 32-bit words, mod 2^32, then bitwise inverted. Emitted as 4 bytes, little-endian.
  - Header checksum covers the 10 header bytes, zero-padded to 12.
  - Payload checksum covers the transmitted payload bytes, zero-padded to a word multiple. Padding is never transmitted.
- State machine: IDLE → HDR (10 bytes) → HCSUM (4 bytes) → PAYLOAD → PFIN (1 cycle) → PCSUM (4 bytes) → IDLE.
  - If the length is 0, HCSUM goes straight to PFIN.
- In PAYLOAD the path is pass-through:
  - `m_axis_tdata = s_axis_tdata`
  - `m_axis_tvalid = s_axis_tvalid`
  - `s_axis_tready = m_axis_tready`
- `s_axis_tready` is 0 in every state except PAYLOAD.
- A payload byte counter counts up to `pkt_len`. PAYLOAD exits when either:
  - the `pkt_len`-th byte is transferred, or
  - a byte with TLAST is transferred earlier. This sets `err_short`; the header is not rewritten.
- If the `pkt_len`-th byte lacks TLAST, `err_long` is set. Remaining input bytes stay stalled until the next packet.
- A word accumulator collects bytes. The running sum is updated on each completed word. PFIN adds any partial word, and `m_axis_tvalid` is 0 during PFIN.
- `m_axis_tlast` = 1 only on PCSUM byte 3.
- If `err_clr` and an error-setting event occur in the same cycle, the error flag is set.

## Timing
- Reset: all outputs are 0, state is IDLE, counters and accumulators are 0. Reset mid-packet abandons the packet immediately with no TLAST.
- Header byte 0 is valid in the cycle after the accepted `start`.
- Header and checksum bytes are registered. Once valid, `m_axis_tdata` and `m_axis_tvalid` hold stable until `m_axis_tready`.
- Full throughput is one byte per cycle while `m_axis_tready` stays high, except the single PFIN bubble.
- A `start` in the same cycle that the last PCSUM byte is accepted is ignored, because `busy` is still 1.
- `busy` falls in the cycle after the final transfer.

## Structure
- Package `pkt_comm_pkg`:
  - header length constant (10)
  - checksum length constant (4)
  - state enum
  - checksum function (sum, invert)
- One sub-module, `pkt_csum32`: byte-in word accumulator with `clr`, `byte_en`, `flush` and `sum` outputs. It is instantiated once and reused for both the header and payload checksums, cleared between them.

## Test plan
- `start` with type=1, id=0x1234, len=4, payload 01 02 03 04 (TLAST on 04), `m_axis_tready`=1 → 22 bytes: `02 01 00 00 04 00 00 00 34 12 C5 EC FF FF 01 02 03 04 FE FD FC FB`, TLAST on byte 22, no errors.
- Same packet with `m_axis_tready` toggling pseudo-randomly → identical byte sequence; data held stable while stalled.
- len=0 → 14 header/checksum bytes followed by `FF FF FF FF`, TLAST on the last byte.
- len=6, TLAST on byte 3 → payload checksum over 3 bytes; `err_short`=1 after the packet; `err_clr` returns it to 0.
- len=2, payload bytes without TLAST → `err_long`=1; the third input byte is not consumed (`s_axis_tready`=0) until the next `start`.
- Assert `CORE_RST` during PAYLOAD → next cycle all outputs 0 and `busy`=0; a subsequent packet frames correctly.
